mux_sel_arb: RTL
================

# mux_sel_arb

Two-requester round-robin arbiter that generates the select line `s` for the downstream `mux_2x1` data mux. It grants one source at a time, holds the grant (and `s`) stable for the whole transfer, and changes `s` only while no grant is active, so the mux output never switches mid-transfer. A compile-time watchdog can force release of a grant that is held too long.

## Interface
- `TIMEOUT`, 15: maximum grant length in cycles. Used only when `MUX_ARB_TIMEOUT_EN` is defined. Legal range is 1..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `req1` input 1: source 1 (mux input `x1`) requests the path; level, held for the whole transfer.
- `req2` input 1: source 2 (mux input `x2`) requests the path; level.
- `done` input 1: one-cycle end-of-transfer pulse from the granted source.
- `gnt1` output 1: grant to source 1; registered.
- `gnt2` output 1: grant to source 2; registered.
- `s` output 1: mux select; 0 = `x1`, 1 = `x2`; registered.
- `busy` output 1: high while either grant is high.
- `timeout` output 1: one-cycle pulse on forced release. Tied 0 without the macro.

## Operation
- States: IDLE, GNT1, GNT2.
- Register `last` records the most recently served source. It resets to 2, so source 1 wins the first tie.
- IDLE transitions:
  - `req1` only → GNT1.
  - `req2` only → GNT2.
  - Both → the source ≠ `last`.
  - Neither → stay in IDLE.
- GNTn transitions:
  - Go to IDLE when `reqn` is sampled low, or `done` is sampled high, whichever comes first. Both together count as a single release.
  - On release, set `last` = n.
- A dead IDLE cycle always follows a release. Back-to-back grants are never adjacent.
- `s` updates only on the IDLE→GNTn transition (GNT1 → 0, GNT2 → 1). It holds its value in IDLE and never changes while `busy` is high.
- `gnt1`, `gnt2` are one-hot or zero; never both high.
- `done` sampled in IDLE is ignored.
- Request on the non-granted side is ignored until the next IDLE.
- Reset mid-grant: all outputs drop immediately (asynchronous), state → IDLE, `last` → 2.
- Reset values: `gnt1`=0, `gnt2`=0, `s`=0, `busy`=0, `timeout`=0.

## Timing
- Grant latency: request sampled at edge N → `gnt`, `s`, `busy` valid after edge N.
- Release latency: `req` low or `done` sampled at edge K → grant low after edge K. The earliest next grant is after edge K+1.
- Round-robin fairness: with both requesters continuously requesting and releasing via `done`, grants alternate 1,2,1,2…
- `busy` is combinationally `gnt1|gnt2` from registered signals. It is glitch-free.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - An 8-bit cycle counter clears on entry to GNTn and increments each granted cycle.
  - When it reaches `TIMEOUT` with the grant still held, the block forces release to IDLE on that edge, sets `last` = n, and pulses `timeout` high for exactly one cycle, coincident with the grant dropping.
  - A normal release on the same edge takes priority; no `timeout` pulse is generated.
- Not defined:
  - No counter.
  - The grant lasts until `req` drops or `done` arrives.
  - `timeout` is constant 0.

## Structure
- Shared package `mux_pkg` holds:
  - the state encoding (IDLE=2'b00, GNT1=2'b01, GNT2=2'b10);
  - the select constants (SEL_X1=0, SEL_X2=1);
  - the counter width constant (8).
- One sub-module, `grant_timer`, holds the clear/increment counter and terminal-count compare. It is instantiated only under `MUX_ARB_TIMEOUT_EN`.

## Test plan
- Reset with `req1`=`req2`=1 held → all outputs 0 during reset. After release: `gnt1`=1, `s`=0 one edge later.
- Both requesting; release each grant with a `done` pulse, 6 times → grant sequence 1,2,1,2,1,2, one IDLE cycle between each. `s` toggles only in IDLE.
- `req2` only, held 5 cycles, then dropped → `gnt2`=1 and `s`=1 for 5 cycles. After the drop: `gnt2`=0 and `s` stays 1.
- Assert `rst` during GNT2 → `gnt2`, `busy`, `s` go 0 without waiting for a clock edge. The next tie then grants source 1.
- With the macro and `TIMEOUT`=4, `req1` held high → `gnt1` high for 4 cycles, `timeout` pulses once, IDLE for 1 cycle, then re-grant to 1. If `req2` is also high, source 2 is granted instead.
- With the macro, `done` on the same edge the count reaches `TIMEOUT` → release with `timeout`=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_sel_arb select arbiter: state encoding,
// mux select values, watchdog counter width and the round-robin tie helper.
// Optional feature macro used by the arbiter: MUX_ARB_TIMEOUT_EN.
package mux_pkg;

    // State encoding; each grant state owns one bit so the grant outputs can
    // be taken straight from the state register.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT1 = 2'b01;
    localparam logic [1:0] ST_GNT2 = 2'b10;

    // Mux select values: x1 is selected by 0, x2 by 1.
    localparam logic SEL_X1 = 1'b0;
    localparam logic SEL_X2 = 1'b1;

    // Width of the grant-length watchdog counter.
    localparam int unsigned CNT_W = 8;

    // Encoding of the most recently served source.
    localparam logic LAST_SRC1 = 1'b0;
    localparam logic LAST_SRC2 = 1'b1;

    // On a tie the source that was not served last wins.
    function automatic logic [1:0] tie_winner(input logic last_src);
        logic [1:0] win;
        if (last_src == LAST_SRC2) begin
            win = ST_GNT1;
        end else begin
            win = ST_GNT2;
        end
        return win;
    endfunction

endpackage

// File: rtl/grant_timer.sv
// Grant-length watchdog for mux_sel_arb. Counts granted cycles, clears while
// no grant is held and flags the cycle in which the count reaches TIMEOUT.
// Only built when MUX_ARB_TIMEOUT_EN is defined.
`ifdef MUX_ARB_TIMEOUT_EN
module grant_timer
    import mux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    output logic expire_o
);

    // The count after the entry edge is 0, so the grant has lasted TIMEOUT
    // cycles once the register holds TIMEOUT-1.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear while idle so every grant starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (active_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = active_i && (cnt_q == TERM_CNT);

endmodule
`endif

// File: rtl/mux_sel_arb.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1
// data mux. The select only moves on the IDLE->GNTn edge, so it never changes
// while a transfer is in flight, and a dead IDLE cycle follows every release.
// Optional feature: MUX_ARB_TIMEOUT_EN adds a watchdog that forces release of
// a grant held for TIMEOUT cycles and pulses timeout on that release.
module mux_sel_arb
    import mux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic done,
    output logic gnt1,
    output logic gnt2,
    output logic s,
    output logic busy,
    output logic timeout
);

    // Reject an out-of-range watchdog length at elaboration.
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("mux_sel_arb: TIMEOUT must be in 1..255");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;
    logic       last_d;
    logic       s_q;
    logic       s_d;
    logic       expire_s;
    logic       tout_d;

`ifdef MUX_ARB_TIMEOUT_EN
    logic       tout_q;

    grant_timer #(
        .TIMEOUT  (TIMEOUT)
    ) u_grant_timer (
        .clk      (clk),
        .rst      (rst),
        .active_i (busy),
        .expire_o (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next-state logic: round-robin pick from IDLE, release on req low or
    // done (or watchdog expiry), recording the served source on release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        s_d     = s_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req1 && req2) begin
                    state_d = tie_winner(last_q);
                    if (tie_winner(last_q) == ST_GNT1) begin
                        s_d = SEL_X1;
                    end else begin
                        s_d = SEL_X2;
                    end
                end else if (req1) begin
                    state_d = ST_GNT1;
                    s_d     = SEL_X1;
                end else if (req2) begin
                    state_d = ST_GNT2;
                    s_d     = SEL_X2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!req1 || done) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_SRC1;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_SRC1;
                    tout_d  = 1'b1;
                end else begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT2: begin
                if (!req2 || done) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_SRC2;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_SRC2;
                    tout_d  = 1'b1;
                end else begin
                    state_d = ST_GNT2;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = SEL_X1;
            end
        endcase
    end

    // Arbiter state, last-served source and mux select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_SRC2;
            s_q     <= SEL_X1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    // Timeout pulse register; high for the single cycle after a forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tout_q <= 1'b0;
        end else begin
            tout_q <= tout_d;
        end
    end

    assign timeout = tout_q;
`else
    assign timeout = 1'b0;
`endif

    // Grants come straight from state register bits, so busy is glitch-free.
    assign gnt1 = state_q[0];
    assign gnt2 = state_q[1];
    assign s    = s_q;
    assign busy = state_q[0] | state_q[1];

endmodule
